// File: rtl/eyearch_io_pkg.sv
// Shared constants for the CPU I/O port bridge: status/control bit positions
// and the CPU port data width.
package eyearch_io_pkg;

  localparam int DATA_W = 16;

  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_EMPTY  = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_TX_OVF    = 4;
  localparam int ST_RX_UDF    = 5;
  localparam int ST_RXCNT_LSB = 8;

  localparam int CT_CLR   = 0;
  localparam int CT_FLUSH = 1;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with a registered head word (0 when empty), flush, and
// full/empty/count derived from a saturating occupancy counter.
module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CW-1:0]     count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = head_q;
  assign count = count_q;

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign push_ok = push && (!full || pop) && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Head is precomputed so it is a clean register; bypass covers a push landing on the new head slot.
  always_comb begin
    head_d = '0;
    if (count_d == '0)
      head_d = '0;
    else if (push_ok && (wr_ptr_q == rd_ptr_d))
      head_d = wdata;
    else
      head_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/io_port_bridge.sv
// CPU I/O port pair peripheral: port writes feed a TX FIFO drained to a
// valid/ready stream; an inbound stream fills an RX FIFO read through the data port.
module io_port_bridge
  import eyearch_io_pkg::*;
#(
  parameter int PORT_BASE = 0,
  parameter int DEPTH     = 8,
  parameter int DATA_W    = eyearch_io_pkg::DATA_W,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_write,
  input  logic              cpu_read,
  input  logic [15:0]       cpu_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0] ctrl_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [15:0]       status,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W-1:0] rx_data
);

  // Streams use valid/ready: a word transfers on any clk edge where both are high;
  // tx_valid and tx_data hold steady until accepted, rx_ready never waits on rx_valid.

  logic          sel_data, sel_ctrl, ctrl_wr, flush;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_ovf_q, tx_ovf_d;
  logic          rx_udf_q, rx_udf_d;
  logic          ctrl_unused;

  assign sel_data = (cpu_addr == 16'(PORT_BASE));
  assign sel_ctrl = (cpu_addr == 16'(PORT_BASE + 1));
  assign ctrl_wr  = cpu_write && sel_ctrl;
  assign flush    = ctrl_wr && ctrl_data[CT_FLUSH];

  assign tx_push  = cpu_write && sel_data;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = cpu_read && sel_data;

  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;

  assign ctrl_unused = ^{ctrl_data[DATA_W-1:2], tx_count};

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .flush (flush),
    .wdata (wr_data),
    .head  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .flush (flush),
    .wdata (rx_data),
    .head  (rd_data),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (ctrl_wr && ctrl_data[CT_CLR]) begin
      tx_ovf_d = 1'b0;
      rx_udf_d = 1'b0;
    end
    if (tx_push && tx_full && !tx_pop) tx_ovf_d = 1'b1;
    if (rx_pop && rx_empty)            rx_udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_ovf_q <= 1'b0;
      rx_udf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_udf_q <= rx_udf_d;
    end
  end

  // Every status field comes straight from a flop, so it shows the state after the last edge.
  always_comb begin
    status                        = '0;
    status[ST_TX_FULL]            = tx_full;
    status[ST_TX_EMPTY]           = tx_empty;
    status[ST_RX_EMPTY]           = rx_empty;
    status[ST_RX_FULL]            = rx_full;
    status[ST_TX_OVF]             = tx_ovf_q;
    status[ST_RX_UDF]             = rx_udf_q;
    status[ST_RXCNT_LSB +: 7]     = 7'(rx_count);
  end

endmodule

// File: tb/tb_io_port_bridge.sv
// Directed bench for io_port_bridge (PORT_BASE=2, DEPTH=8) with hand-computed
// expected values checked by immediate assertions.
module tb_io_port_bridge;

  localparam logic [15:0] A_DATA  = 16'd2;
  localparam logic [15:0] A_CTRL  = 16'd3;
  localparam logic [15:0] A_OTHER = 16'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_write, cpu_read;
  logic [15:0] cpu_addr, wr_data, ctrl_data;
  logic [15:0] rd_data, status, tx_data, rx_data;
  logic        tx_valid, tx_ready, rx_valid, rx_ready;

  int n_assert = 0;
  int n_fail   = 0;

  io_port_bridge #(.PORT_BASE(2), .DEPTH(8), .DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_write (cpu_write),
    .cpu_read  (cpu_read),
    .cpu_addr  (cpu_addr),
    .wr_data   (wr_data),
    .ctrl_data (ctrl_data),
    .rd_data   (rd_data),
    .status    (status),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1);
  end

  // Driver helpers: inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_write = 1'b0;
    cpu_read  = 1'b0;
    cpu_addr  = A_OTHER;
  endtask

  task automatic cpu_wr(input logic [15:0] addr, input logic [15:0] d);
    cpu_write = 1'b1;
    cpu_addr  = addr;
    if (addr == A_CTRL) ctrl_data = d;
    else wr_data = d;
    tick();
    idle();
  endtask

  task automatic cpu_rd(input logic [15:0] addr);
    cpu_read = 1'b1;
    cpu_addr = addr;
    tick();
    idle();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cpu_write = 1'b0; cpu_read = 1'b0; cpu_addr = A_OTHER;
    wr_data = '0; ctrl_data = '0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset / idle
    chk("rst_status",   status, 16'h0006);
    chk("rst_tx_valid", {15'd0, tx_valid}, 16'd0);
    chk("rst_rx_ready", {15'd0, rx_ready}, 16'd1);
    chk("rst_rd_data",  rd_data, 16'h0000);
    chk("rst_tx_data",  tx_data, 16'h0000);

    // Two TX words, stalled sink
    cpu_wr(A_DATA, 16'h1234);
    chk("tx1_valid", {15'd0, tx_valid}, 16'd1);
    chk("tx1_data",  tx_data, 16'h1234);
    cpu_wr(A_DATA, 16'hABCD);
    chk("tx2_hold",   tx_data, 16'h1234);
    chk("tx2_status", status, 16'h0004);
    cpu_wr(A_OTHER, 16'h5555);
    chk("decode_ignore", status, 16'h0004);
    tx_ready = 1'b1;
    tick();
    chk("drain1_data", tx_data, 16'hABCD);
    chk("drain1_valid", {15'd0, tx_valid}, 16'd1);
    tick();
    tx_ready = 1'b0;
    chk("drain2_valid", {15'd0, tx_valid}, 16'd0);
    chk("drain2_status", status, 16'h0006);

    // TX overflow with 9 writes, then full push+pop
    for (int i = 0; i < 9; i++) cpu_wr(A_DATA, 16'h0100 + 16'(i));
    chk("ovf_status", status, 16'h0015);
    cpu_wr(A_CTRL, 16'h0001);
    chk("ovf_clear", status, 16'h0005);
    tx_ready = 1'b1;
    cpu_wr(A_DATA, 16'h0200);
    tx_ready = 1'b0;
    chk("full_pushpop_status", status, 16'h0005);
    chk("full_pushpop_head", tx_data, 16'h0101);
    tx_ready = 1'b1;
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("ovf_drain%0d", i), tx_data, 16'h0100 + 16'(i));
      tick();
    end
    chk("ovf_drain_last", tx_data, 16'h0200);
    tick();
    tx_ready = 1'b0;
    chk("ovf_drain_empty", {15'd0, tx_valid}, 16'd0);
    chk("ovf_drain_status", status, 16'h0006);

    // RX words 5,6,7 then reads and underflow
    rx_valid = 1'b1;
    for (int i = 5; i < 8; i++) begin
      rx_data = 16'(i);
      tick();
    end
    rx_valid = 1'b0;
    chk("rx3_status", status, 16'h0302);
    chk("rx3_head", rd_data, 16'h0005);
    cpu_rd(A_CTRL);
    chk("ctrl_read_status", status, 16'h0302);
    chk("ctrl_read_head", rd_data, 16'h0005);
    cpu_rd(A_DATA);
    chk("rx_rd1", rd_data, 16'h0006);
    cpu_rd(A_DATA);
    chk("rx_rd2", rd_data, 16'h0007);
    cpu_rd(A_DATA);
    chk("rx_rd3", rd_data, 16'h0000);
    chk("rx_rd3_status", status, 16'h0006);
    cpu_rd(A_DATA);
    chk("udf_rd_data", rd_data, 16'h0000);
    chk("udf_status", status, 16'h0026);
    cpu_wr(A_CTRL, 16'h0001);
    chk("udf_clear", status, 16'h0006);

    // Fill RX, backpressure, one pop lets the held word in
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 16'h0010 + 16'(i);
      tick();
    end
    rx_data = 16'h0099;
    chk("rx_full_ready", {15'd0, rx_ready}, 16'd0);
    chk("rx_full_status", status, 16'h080A);
    tick();
    chk("rx_full_hold", status, 16'h080A);
    chk("rx_full_head", rd_data, 16'h0010);
    cpu_rd(A_DATA);
    chk("rx_pop_status", status, 16'h0702);
    chk("rx_pop_ready", {15'd0, rx_ready}, 16'd1);
    tick();
    rx_valid = 1'b0;
    chk("rx_refill_status", status, 16'h080A);
    for (int i = 1; i < 8; i++) begin
      chk($sformatf("rx_drain%0d", i), rd_data, 16'h0010 + 16'(i));
      cpu_rd(A_DATA);
    end
    chk("rx_drain_last", rd_data, 16'h0099);
    cpu_rd(A_DATA);
    chk("rx_drain_empty", rd_data, 16'h0000);
    chk("rx_drain_status", status, 16'h0006);

    // Push and pop together on empty RX
    rx_valid = 1'b1;
    rx_data  = 16'h0077;
    cpu_rd(A_DATA);
    rx_valid = 1'b0;
    chk("empty_pushpop_data", rd_data, 16'h0077);
    chk("empty_pushpop_status", status, 16'h0122);
    cpu_wr(A_CTRL, 16'h0001);
    chk("empty_pushpop_clr", status, 16'h0102);

    // Flush discards contents and same-cycle handshakes
    rx_valid = 1'b1;
    rx_data  = 16'h0088;
    cpu_wr(A_DATA, 16'h00A0);
    rx_valid = 1'b0;
    cpu_wr(A_DATA, 16'h00A1);
    cpu_wr(A_DATA, 16'h00A2);
    chk("preflush_status", status, 16'h0200);
    rx_valid = 1'b1;
    rx_data  = 16'h0055;
    tx_ready = 1'b1;
    cpu_wr(A_CTRL, 16'h0002);
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    chk("flush_status", status, 16'h0006);
    chk("flush_tx_valid", {15'd0, tx_valid}, 16'd0);
    chk("flush_rd_data", rd_data, 16'h0000);

    // Reset in the middle of a drain
    rx_valid = 1'b1;
    rx_data  = 16'h0066;
    cpu_wr(A_DATA, 16'h00C0);
    rx_valid = 1'b0;
    cpu_wr(A_DATA, 16'h00C1);
    cpu_wr(A_DATA, 16'h00C2);
    tx_ready = 1'b1;
    tick();
    chk("middrain_data", tx_data, 16'h00C1);
    rst_n = 1'b0;
    tick();
    chk("midrst_tx_valid", {15'd0, tx_valid}, 16'd0);
    chk("midrst_tx_data", tx_data, 16'h0000);
    chk("midrst_rd_data", rd_data, 16'h0000);
    chk("midrst_status", status, 16'h0006);
    chk("midrst_rx_ready", {15'd0, rx_ready}, 16'd1);
    rst_n = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("postrst_tx_valid", {15'd0, tx_valid}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
